// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared constants and state type for the TDM demultiplexer
package tdm_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Channel that follows ch in frame order, wrapping 15 -> 0.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/decoder4to16.sv
// rtl/decoder4to16.sv - 4-bit index plus enable to 16-bit one-hot write enables
module decoder4to16
  import tdm_pkg::*;
(
  input  logic              en,
  input  logic [SEL_W-1:0]  idx,
  output logic [NUM_CH-1:0] onehot
);

  // One output bit per slot; all zero when the enable is low.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      onehot[k] = en && (idx == SEL_W'(k));
    end
  end

endmodule

// File: rtl/tdm_demux16.sv
// rtl/tdm_demux16.sv - 1-to-16 TDM demultiplexer with sof-aligned channel counter
module tdm_demux16
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    sof,
  input  logic                    auto_mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_strobe,
  output logic [SEL_W-1:0]        cur_ch,
  output logic                    frame_done,
  output logic                    sync_err,
  output logic                    locked
);

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   cur_ch_next;
  logic               wr_en;
  logic [SEL_W-1:0]   wr_idx;
  logic [NUM_CH-1:0]  wr_onehot;
  logic               frame_done_next;
  logic               sync_err_next;

  // Decide which slot (if any) takes this word, and the next counter/state.
  always_comb begin
    state_next      = state;
    cur_ch_next     = cur_ch;
    wr_en           = 1'b0;
    wr_idx          = '0;
    frame_done_next = 1'b0;
    sync_err_next   = 1'b0;
    if (din_valid) begin
      if (!auto_mode) begin
        // Manual routing leaves alignment untouched so auto mode can resume.
        wr_en  = 1'b1;
        wr_idx = sel;
      end else begin
        case (state)
          HUNT: begin
            if (sof) begin
              wr_en       = 1'b1;
              wr_idx      = '0;
              cur_ch_next = SEL_W'(1);
              state_next  = TRACK;
            end
          end
          TRACK: begin
            wr_en = 1'b1;
            if (sof) begin
              // A marker always realigns to channel 0, even mid-frame.
              wr_idx        = '0;
              cur_ch_next   = SEL_W'(1);
              sync_err_next = (cur_ch != '0);
            end else begin
              wr_idx          = cur_ch;
              cur_ch_next     = next_ch(cur_ch);
              frame_done_next = (cur_ch == SEL_W'(NUM_CH - 1));
            end
          end
          default: state_next = HUNT;
        endcase
      end
    end
  end

  decoder4to16 u_dec (
    .en     (wr_en),
    .idx    (wr_idx),
    .onehot (wr_onehot)
  );

  // Counter, FSM and status pulses; reset drops any word in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      cur_ch     <= '0;
      ch_strobe  <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_next;
      cur_ch     <= cur_ch_next;
      ch_strobe  <= wr_onehot;
      frame_done <= frame_done_next;
      sync_err   <= sync_err_next;
    end
  end

  // Holding slots: each keeps its word until its own enable fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_data <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_onehot[k]) begin
          ch_data[k*WIDTH +: WIDTH] <= din;
        end
      end
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_tdm_demux16.sv
// tb/tb_tdm_demux16.sv - randomized and directed bench against a frame-level model
module tb_tdm_demux16;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          sof;
  logic          auto_mode;
  logic [3:0]    sel;
  logic [16*W-1:0] ch_data;
  logic [15:0]   ch_strobe;
  logic [3:0]    cur_ch;
  logic          frame_done;
  logic          sync_err;
  logic          locked;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_slot [16];
  int           m_ch;
  bit           m_locked;
  logic [15:0]  m_strobe;
  bit           m_fd;
  bit           m_se;

  tdm_demux16 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .auto_mode  (auto_mode),
    .sel        (sel),
    .ch_data    (ch_data),
    .ch_strobe  (ch_strobe),
    .cur_ch     (cur_ch),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: a word lands in the channel it names, the counter
  // is simply "one past the last auto-mode channel written".
  task automatic model_update(input bit r, input bit v, input bit s, input bit a,
                              input logic [3:0] sl, input logic [W-1:0] d);
    int target;
    m_strobe = '0;
    m_fd     = 0;
    m_se     = 0;
    if (r) begin
      for (int k = 0; k < 16; k++) m_slot[k] = '0;
      m_ch     = 0;
      m_locked = 0;
    end else if (v) begin
      if (!a) begin
        m_slot[sl] = d;
        m_strobe   = 16'(1) << sl;
      end else if (!m_locked) begin
        if (s) begin
          m_slot[0] = d;
          m_strobe  = 16'h0001;
          m_ch      = 1;
          m_locked  = 1;
        end
      end else begin
        target = s ? 0 : m_ch;
        m_se   = s && (m_ch != 0);
        m_fd   = !s && (m_ch == 15);
        m_slot[target] = d;
        m_strobe = 16'(1) << target;
        m_ch = (target + 1) % 16;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [16*W-1:0] exp_data;
    for (int k = 0; k < 16; k++) exp_data[k*W +: W] = m_slot[k];
    check_eq({tag, ".ch_data"},    64'(ch_data),    64'(exp_data));
    check_eq({tag, ".ch_strobe"},  64'(ch_strobe),  64'(m_strobe));
    check_eq({tag, ".cur_ch"},     64'(cur_ch),     64'(m_ch));
    check_eq({tag, ".frame_done"}, 64'(frame_done), 64'(m_fd));
    check_eq({tag, ".sync_err"},   64'(sync_err),   64'(m_se));
    check_eq({tag, ".locked"},     64'(locked),     64'(m_locked));
  endtask

  task automatic step(input string tag, input bit r, input bit v, input bit s, input bit a,
                      input logic [3:0] sl, input logic [W-1:0] d);
    rst       = r;
    din_valid = v;
    sof       = s;
    auto_mode = a;
    sel       = sl;
    din       = d;
    @(posedge clk);
    #1;
    model_update(r, v, s, a, sl, d);
    compare_all(tag);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) m_slot[k] = '0;
    m_ch = 0; m_locked = 0; m_strobe = '0; m_fd = 0; m_se = 0;
    rst = 1; din_valid = 0; sof = 0; auto_mode = 1; sel = '0; din = '0;

    step("reset", 1, 0, 0, 1, 0, 0);
    step("reset", 1, 1, 1, 1, 0, 4'h7);

    // Full frame 0..F with sof on the first word.
    for (int k = 0; k < 16; k++) begin
      step("frame", 0, 1, k == 0, 1, 0, W'(k));
      check_eq("frame.strobe_bit", 64'(ch_strobe), 64'(16'(1) << k));
      if (k >= 1) check_eq("frame.locked_on", 64'(locked), 64'(1));
    end
    check_eq("frame.slot15", 64'(ch_data[15*W +: W]), 64'hF);

    // Hunt: words without sof are dropped, then sof 0xA locks.
    step("hunt_rst", 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step("hunt_drop", 0, 1, 0, 1, 0, W'($urandom_range(0, 15)));
      check_eq("hunt.no_strobe", 64'(ch_strobe), 64'(0));
    end
    step("hunt_sof", 0, 1, 1, 1, 0, 4'hA);
    check_eq("hunt.slot0", 64'(ch_data[0 +: W]), 64'hA);
    check_eq("hunt.cur_ch", 64'(cur_ch), 64'(1));

    // Advance to channel 7, then a misplaced sof.
    for (int k = 1; k < 7; k++) step("to7", 0, 1, 0, 1, 0, W'(k + 8));
    check_eq("sync.cur_ch7", 64'(cur_ch), 64'(7));
    step("sync_sof", 0, 1, 1, 1, 0, 4'h3);
    check_eq("sync.err", 64'(sync_err), 64'(1));
    check_eq("sync.slot0", 64'(ch_data[0 +: W]), 64'h3);
    check_eq("sync.cur_ch", 64'(cur_ch), 64'(1));

    // Manual write to slot 9, sof ignored.
    step("manual", 0, 1, 1, 0, 4'd9, 4'h5);
    check_eq("manual.strobe", 64'(ch_strobe), 64'h0200);
    check_eq("manual.slot9", 64'(ch_data[9*W +: W]), 64'h5);
    check_eq("manual.cur_ch", 64'(cur_ch), 64'(1));

    // Reset mid-frame at channel 12 with a word present.
    step("r12_sof", 0, 1, 1, 1, 0, 4'h1);
    for (int k = 1; k < 12; k++) step("r12_fill", 0, 1, 0, 1, 0, W'(15 - k));
    check_eq("r12.cur_ch", 64'(cur_ch), 64'(12));
    step("r12_rst", 1, 1, 0, 1, 0, 4'hE);
    check_eq("r12.data_zero", 64'(ch_data), 64'(0));
    check_eq("r12.unlocked", 64'(locked), 64'(0));
    for (int k = 0; k < 16; k++) step("r12_refill", 0, 1, k == 0, 1, 0, W'(k ^ 5));

    // Three-cycle gap between channels 4 and 5.
    step("gap_sof", 0, 1, 1, 1, 0, 4'h0);
    for (int k = 1; k < 5; k++) step("gap_pre", 0, 1, 0, 1, 0, W'(k));
    for (int k = 0; k < 3; k++) begin
      step("gap_idle", 0, 0, 0, 1, 0, W'($urandom_range(0, 15)));
      check_eq("gap.no_strobe", 64'(ch_strobe), 64'(0));
    end
    step("gap_ch5", 0, 1, 0, 1, 0, 4'hC);
    check_eq("gap.slot5", 64'(ch_data[5*W +: W]), 64'hC);
    check_eq("gap.strobe5", 64'(ch_strobe), 64'h0020);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           $urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) != 0,
           4'($urandom_range(0, 15)),
           W'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
